// File: rtl/blit_cmdif_pkg.sv
// blit_cmdif_pkg: shared definitions for the blitter command/status front end.
//   - blit_state_t : blit lifecycle encoding, also reported in status bits[3:2]
//   - STAT_*       : status word bit positions
//   - *_OFS_DEF    : default register offsets within blitter space
//   - status_word(): assembles the status word the front end drives
package blit_cmdif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STOP  = 2'd2,
        ST_ABORT = 2'd3
    } blit_state_t;

    localparam int STAT_IDLE  = 0;
    localparam int STAT_STOPB = 1;   // owned by the stop stage, never driven here
    localparam int STAT_ST_LO = 2;
    localparam int STAT_ERR   = 4;
    localparam int STAT_INT   = 5;

    localparam logic [7:0] CMD_OFS_DEF  = 8'h38;
    localparam logic [7:0] STOP_OFS_DEF = 8'h54;

    function automatic logic [31:0] status_word(blit_state_t st, logic err, logic bint);
        logic [31:0] w;
        w                          = '0;
        w[STAT_IDLE]               = (st == ST_IDLE);
        w[STAT_ST_LO+1:STAT_ST_LO] = st;
        w[STAT_ERR]                = err;
        w[STAT_INT]                = bint;
        return w;
    endfunction

endpackage

// File: rtl/blit_cmdif_if.sv
// blit_cmdif_if: GPU register access bus into the blitter command front end.
//   gpu_addr/gpu_wr/gpu_rd/gpu_din : GPU -> blitter (offset, strobes, write data)
//   gpu_dout/gpu_dout_oe           : blitter -> GPU (status data, per-bit enable)
interface blit_cmdif_if;
    logic [7:0]  gpu_addr;
    logic        gpu_wr;
    logic        gpu_rd;
    logic [31:0] gpu_din;
    logic [31:0] gpu_dout;
    logic [31:0] gpu_dout_oe;

    modport master (output gpu_addr, gpu_wr, gpu_rd, gpu_din,
                    input  gpu_dout, gpu_dout_oe);
    modport slave  (input  gpu_addr, gpu_wr, gpu_rd, gpu_din,
                    output gpu_dout, gpu_dout_oe);
endinterface

// File: rtl/blit_cmdif_clk_edge.sv
// clk_edge: detects the rising edge of the level blitter phase clock `clk`
// in the sys_clk domain.
//   sys_clk  in  system clock
//   clk      in  blitter phase clock level
//   clk_rise out clk high now, low on previous sys_clk
// The old-clk register is deliberately not reset so a reset pulse never
// fabricates or swallows a phase edge.
module clk_edge (
    input  logic sys_clk,
    input  logic clk,
    output logic clk_rise
);
    logic clk_q;

    always_ff @(posedge sys_clk)
        clk_q <= clk;

    assign clk_rise = clk & ~clk_q;
endmodule

// File: rtl/blit_cmdif.sv
// blit_cmdif: GPU-facing command/status front end of the blitter.
//   sys_clk, resetl    system clock, synchronous active-low reset
//   clk                blitter phase clock (level); state moves on its rise
//   gpu                GPU register bus (slave side)
//   blit_done          loop sequencer finished (level)
//   stopped, reset_n   from the collision stop stage
//   stopld             B_STOP write strobe, one blitter period
//   statrd             B_CMD read enable (combinational)
//   go                 start pulse to the loop sequencer, one blitter period
//   cmd                latched command word
//   blit_int           completion interrupt (level)
module blit_cmdif
    import blit_cmdif_pkg::*;
#(
    parameter logic [7:0] CMD_OFS  = CMD_OFS_DEF,
    parameter logic [7:0] STOP_OFS = STOP_OFS_DEF
) (
    input  logic              sys_clk,
    input  logic              resetl,
    input  logic              clk,
    blit_cmdif_if.slave       gpu,
    input  logic              blit_done,
    input  logic              stopped,
    input  logic              reset_n,
    output logic              stopld,
    output logic              statrd,
    output logic              go,
    output logic [31:0]       cmd,
    output logic              blit_int
);
    logic        clk_rise;
    logic        cmd_wr, stop_wr, stat_rd;
    logic        cmd_wr_q, stop_wr_q, stat_rd_q;
    logic        cmd_new, stop_new, stat_new;
    logic        int_set, int_clr;
    logic        err;
    blit_state_t state;

    clk_edge u_clk_edge (
        .sys_clk  (sys_clk),
        .clk      (clk),
        .clk_rise (clk_rise)
    );

    assign cmd_wr  = gpu.gpu_wr & (gpu.gpu_addr == CMD_OFS);
    assign stop_wr = gpu.gpu_wr & (gpu.gpu_addr == STOP_OFS);
    assign stat_rd = gpu.gpu_rd & (gpu.gpu_addr == CMD_OFS);

    // Strobe history is sampled only on phase rises, so an access held over
    // several blitter periods acts exactly once, on its first rise.
    assign cmd_new  = cmd_wr  & ~cmd_wr_q;
    assign stop_new = stop_wr & ~stop_wr_q;
    assign stat_new = stat_rd & ~stat_rd_q;

    // Completion sets only on a clean RUN -> IDLE exit; a collision stop on
    // the same edge wins and leaves the interrupt alone.
    assign int_set = (state == ST_RUN) & ~stopped & blit_done;
    assign int_clr = stat_new | (cmd_new & (state == ST_IDLE));

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state     <= ST_IDLE;
            cmd       <= '0;
            go        <= 1'b0;
            stopld    <= 1'b0;
            err       <= 1'b0;
            blit_int  <= 1'b0;
            cmd_wr_q  <= 1'b0;
            stop_wr_q <= 1'b0;
            stat_rd_q <= 1'b0;
        end else if (clk_rise) begin
            cmd_wr_q  <= cmd_wr;
            stop_wr_q <= stop_wr;
            stat_rd_q <= stat_rd;
            go        <= 1'b0;
            stopld    <= stop_new;

            case (state)
                ST_IDLE:
                    if (cmd_new) begin
                        state <= ST_RUN;
                        cmd   <= gpu.gpu_din;
                        go    <= 1'b1;
                    end
                ST_RUN:
                    if (stopped)        state <= ST_STOP;
                    else if (blit_done) state <= ST_IDLE;
                ST_STOP:
                    if (!reset_n)       state <= ST_ABORT;
                    else if (!stopped)  state <= ST_RUN;
                ST_ABORT:
                    if (reset_n)        state <= ST_IDLE;
                default:                state <= ST_IDLE;
            endcase

            // A write is accepted only in IDLE; anything else flags err.
            if (cmd_new)
                err <= (state != ST_IDLE);

            if (int_set)      blit_int <= 1'b1;
            else if (int_clr) blit_int <= 1'b0;
        end
    end

    assign statrd          = stat_rd;
    assign gpu.gpu_dout    = status_word(state, err, blit_int);
    assign gpu.gpu_dout_oe = {{30{stat_rd}}, 1'b0, stat_rd};

endmodule

// File: tb/tb_blit_cmdif.sv
module tb_blit_cmdif;
    import blit_cmdif_pkg::*;

    localparam logic [7:0] CO = 8'h38;
    localparam logic [7:0] SO = 8'h54;

    logic sys_clk, resetl, clk;
    logic blit_done, stopped, reset_n;
    logic stopld, statrd, go, blit_int;
    logic [31:0] cmd;

    blit_cmdif_if bus();

    blit_cmdif #(.CMD_OFS(CO), .STOP_OFS(SO)) dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .clk       (clk),
        .gpu       (bus),
        .blit_done (blit_done),
        .stopped   (stopped),
        .reset_n   (reset_n),
        .stopld    (stopld),
        .statrd    (statrd),
        .go        (go),
        .cmd       (cmd),
        .blit_int  (blit_int)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got event, want none queued / got none, want one", nm);
    endtask

    // Expected view after each blitter-phase rise.
    typedef struct packed {
        logic [1:0]  st;
        logic        err;
        logic        bint;
        logic        rd;
        logic [31:0] cmd;
    } exp_t;

    exp_t        st_q[$];
    logic [31:0] go_q[$];
    logic [31:0] sl_q[$];

    // Reference model: lifecycle as an integer state 0..3 plus flags.
    int          m_st;
    bit          m_err, m_int;
    logic [31:0] m_cmd;
    bit          p_cw, p_sw, p_sr;

    task automatic model_reset();
        m_st = 0; m_err = 0; m_int = 0; m_cmd = 0;
        p_cw = 0; p_sw = 0; p_sr = 0;
    endtask

    // One blitter period: inputs change while clk is low, the model predicts
    // the outcome of the upcoming rise, then the rise happens.
    task automatic step(input bit wr, input bit rd, input logic [7:0] a,
                        input logic [31:0] d, input bit done, input bit stp, input bit rn);
        bit   cw, sw, sr, cwn, swn, srn, set_i, clr_i;
        int   nxt;
        exp_t e;
        @(posedge sys_clk); #1;
        clk = 1'b0;
        bus.gpu_wr = wr; bus.gpu_rd = rd; bus.gpu_addr = a; bus.gpu_din = d;
        blit_done = done; stopped = stp; reset_n = rn;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        clk = 1'b1;

        cw = wr && (a == CO); sw = wr && (a == SO); sr = rd && (a == CO);
        cwn = cw && !p_cw; swn = sw && !p_sw; srn = sr && !p_sr;
        p_cw = cw; p_sw = sw; p_sr = sr;
        set_i = 0; clr_i = srn; nxt = m_st;
        if (cwn) begin
            if (m_st == 0) begin
                m_cmd = d; go_q.push_back(d); clr_i = 1; m_err = 0; nxt = 1;
            end else m_err = 1;
        end
        if (m_st == 1) begin
            if (stp) nxt = 2;
            else if (done) begin nxt = 0; set_i = 1; end
        end else if (m_st == 2) begin
            if (!rn) nxt = 3;
            else if (!stp) nxt = 1;
        end else if (m_st == 3) begin
            if (rn) nxt = 0;
        end
        m_st = nxt;
        if (set_i) m_int = 1; else if (clr_i) m_int = 0;
        if (swn) sl_q.push_back(d);
        e.st = 2'(m_st); e.err = m_err; e.bint = m_int; e.rd = sr; e.cmd = m_cmd;
        st_q.push_back(e);
        @(posedge sys_clk);
    endtask

    // Monitor: checks the registered view at each phase rise and every
    // go / stopld pulse against the scoreboard queues.
    int   hi_cnt = 0, go_w = 0, sl_w = 0;
    logic go_d = 1'b0, sl_d = 1'b0;
    always @(negedge sys_clk) begin
        exp_t e;
        logic [31:0] xd;
        if (!resetl) begin
            hi_cnt = 0; go_w = 0; sl_w = 0; go_d = 0; sl_d = 0;
        end else begin
            hi_cnt = clk ? hi_cnt + 1 : 0;
            if (hi_cnt == 2) begin
                if (st_q.size() == 0) miss("status queue");
                else begin
                    e  = st_q.pop_front();
                    xd = {26'd0, e.bint, e.err, e.st, 1'b0, (e.st == 2'd0)};
                    chk("gpu_dout", bus.gpu_dout, xd);
                    chk("blit_int", {31'd0, blit_int}, {31'd0, e.bint});
                    chk("cmd", cmd, e.cmd);
                    chk("statrd", {31'd0, statrd}, {31'd0, e.rd});
                    chk("oe", bus.gpu_dout_oe, e.rd ? 32'hFFFF_FFFD : 32'h0);
                end
            end
            if (go && !go_d) begin
                if (go_q.size() == 0) miss("go unexpected");
                else chk("go cmd", cmd, go_q.pop_front());
            end
            if (go) go_w++;
            else if (go_d) begin chk("go width", go_w, 4); go_w = 0; end
            go_d = go;
            if (stopld && !sl_d) begin
                if (sl_q.size() == 0) miss("stopld unexpected");
                else chk("stopld din", bus.gpu_din, sl_q.pop_front());
            end
            if (stopld) sl_w++;
            else if (sl_d) begin chk("stopld width", sl_w, 4); sl_w = 0; end
            sl_d = stopld;
        end
    end

    task automatic do_reset();
        @(posedge sys_clk); #1;
        clk = 1'b0; bus.gpu_wr = 0; bus.gpu_rd = 0;
        resetl = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 resetl = 1'b1;
        model_reset();
        @(negedge sys_clk);
        chk("rst dout", bus.gpu_dout, 32'h1);
        chk("rst cmd", cmd, 32'h0);
        chk("rst go/stopld/int", {29'd0, go, stopld, blit_int}, 32'h0);
    endtask

    initial begin
        int acc;
        bit stp;
        logic [7:0] a;
        logic [7:0] offs [3];
        offs[0] = CO; offs[1] = SO; offs[2] = 8'h10;
        clk = 0; resetl = 0; blit_done = 0; stopped = 0; reset_n = 1;
        bus.gpu_wr = 0; bus.gpu_rd = 0; bus.gpu_addr = 0; bus.gpu_din = 0;
        do_reset();

        // directed walk through the lifecycle
        step(0,1,CO,0,0,0,1);            // status read after reset
        step(1,0,CO,32'h101,0,0,1);      // start
        step(0,0,CO,0,1,0,1);            // done -> IDLE, int
        step(0,1,CO,0,0,0,1);            // read clears int
        step(0,0,CO,0,0,0,1);
        step(1,0,SO,32'h4,0,0,1);        // stopld
        step(0,0,SO,0,0,0,1);
        step(1,0,CO,32'h55,0,0,1);       // RUN
        step(0,0,CO,0,0,1,1);            // STOP
        step(0,1,CO,0,1,1,1);            // held in STOP, read 0x08
        step(0,0,CO,0,0,0,1);            // resume
        step(1,0,CO,32'h77,0,0,1);       // rejected -> err
        step(0,0,CO,0,1,0,1);            // done
        step(1,0,CO,32'h99,0,0,1);       // accepted, clears err/int
        step(0,0,CO,0,0,1,1);            // STOP
        step(0,0,CO,0,0,1,0);            // ABORT
        step(0,0,CO,0,0,1,0);
        step(0,0,CO,0,0,0,1);            // IDLE, no int
        step(1,0,CO,32'hAA,0,0,1);
        step(0,0,CO,0,0,0,1);
        step(1,0,CO,32'hBB,1,0,1);       // cmd_wr with done in RUN
        step(0,0,CO,0,0,0,1);
        step(1,0,CO,32'hCC,0,0,1);       // RUN then reset mid-blit
        step(0,0,CO,0,0,0,1);
        do_reset();

        stp = 0;
        for (int i = 0; i < 300; i++) begin
            acc = int'($urandom_range(0, 5));
            a   = offs[$urandom_range(0, 2)];
            if ($urandom_range(0, 3) == 0) stp = ~stp;
            step(acc == 0, acc == 1, a, $urandom, $urandom_range(0, 3) == 0,
                 stp, $urandom_range(0, 5) != 0);
        end
        step(0,0,CO,0,0,0,1);
        step(0,0,CO,0,0,0,1);
        repeat (8) @(posedge sys_clk);
        chk("go queue drained", go_q.size(), 0);
        chk("stopld queue drained", sl_q.size(), 0);
        chk("status queue drained", st_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blit_cmdif.md
# blit_cmdif

GPU-facing command/status front end of the blitter, directly upstream of the collision-stop stage. Decodes GPU register accesses into the stop stage's control strobes (`stopld`, `statrd`, shared data bus). Issues the blit start pulse and tracks blit lifecycle (idle / running / collision-stopped / aborting). Drives the status word (all bits except bit 1, which the stop stage owns) and raises a completion interrupt.

## Interface
- `CMD_OFS`, default 8'h38: register offset of B_CMD (write = command, read = status).
- `STOP_OFS`, default 8'h54: register offset of B_STOP (collision control).
- `sys_clk`  in  1  system clock; all state is registered on it.
- `resetl`  in  1  reset, synchronous, active-low; clock sys_clk.
- `clk`  in  1  blitter phase clock (level); state advances only on `clk_rise` = `clk` high now, low on previous sys_clk.
- `gpu_addr`  in  8  register offset within blitter space.
- `gpu_wr`, `gpu_rd`  in  1  access strobes, held ≥1 clk period.
- `gpu_din`  in  32  GPU write data (forwarded to stop stage).
- `blit_done`  in  1  inner/outer loop finished (level, from loop sequencer).
- `stopped`  in  1  from stop stage.
- `reset_n`  in  1  from stop stage; low while `xreset_n` high = collision abort.
- `stopld`  out  1  B_STOP write strobe.
- `statrd`  out  1  status read enable (B_CMD read).
- `go`  out  1  start pulse to loop sequencer.
- `cmd`  out  32  latched command word.
- `gpu_dout`  out  32  status data; `gpu_dout_oe` out 32 per-bit enable (bit 1 always 0).
- `blit_int`  out  1  completion interrupt (level).

## Operation
- Decode: `cmd_wr` = gpu_wr & addr==CMD_OFS; `stop_wr` = gpu_wr & addr==STOP_OFS; `stat_rd` = gpu_rd & addr==CMD_OFS. Each edge-qualified: acts once per access, on first `clk_rise` with the strobe high.
- `stopld` = registered single-clk-period pulse on `stop_wr`; `statrd` = combinational `stat_rd` level.
- FSM states IDLE=0, RUN=1, STOP=2, ABORT=3, evaluated on `clk_rise`:
  - IDLE → RUN on `cmd_wr`: `cmd` ← gpu_din, `go` pulses one clk period.
  - RUN → IDLE on `blit_done`; sets `blit_int`.
  - RUN → STOP on `stopped`=1 (takes priority over `blit_done` in same edge).
  - STOP → RUN when `stopped`=0 and `reset_n`=1 (resume).
  - STOP → ABORT when `reset_n`=0; ABORT → IDLE when `reset_n` returns 1; abort does not set `blit_int`.
- `cmd_wr` outside IDLE: ignored (no `go`, `cmd` unchanged), sets sticky `err`; cleared by next accepted `cmd_wr`.
- `blit_int` cleared on `stat_rd` or accepted `cmd_wr`; a set and a clear on the same edge → set wins.
- Status word: bit0 idle (state==IDLE), bit1 not driven, bits[3:2] FSM state, bit4 `err`, bit5 `blit_int`, rest 0. `gpu_dout_oe` = {30{statrd}}, 0, statrd}.

## Timing
- Reset (resetl low at sys_clk edge, independent of `clk`): state IDLE, `cmd`=0, `go`=0, `stopld`=0, `err`=0, `blit_int`=0, `gpu_dout`=0x1. Reset mid-blit returns to IDLE with no interrupt.
- `go` and `stopld` assert on the sys_clk edge coinciding with `clk_rise` and deassert at the next `clk_rise` (one blitter period).
- Status read reflects state registered at last `clk_rise`; zero additional latency.
- Simultaneous `cmd_wr` and `blit_done` in RUN: RUN → IDLE, command rejected, `err` set.

## Structure
- Shared package: FSM state encoding, status bit indices, default offsets.
- One sub-module natural: `clk_edge` (old-clk register producing `clk_rise`), reusable across blitter stages.

## Test plan
- Reset, then read status → gpu_dout=0x00000001, oe=0xFFFFFFFD, blit_int=0.
- Write B_CMD 0x00000101 in IDLE → cmd=0x101, one go pulse, status bits[3:2]=01; assert blit_done → state IDLE, blit_int=1; status read clears it.
- Write B_STOP 0x4 → stopld pulses exactly one clk period, gpu_din passes 0x4.
- RUN, stopped=1 → STOP (status 0x08 with bit0=0); stopped=0 → RUN, no interrupt.
- STOP, reset_n=0 for 2 clk periods → ABORT then IDLE, blit_int stays 0.
- B_CMD write during RUN → no go, cmd unchanged, status bit4=1; next IDLE write clears it.
